// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, load/store and memory signal bundle for mem_arbiter
interface mem_arbiter_if;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_kill_i;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        ls_req_i;
    logic        ls_wen_i;
    logic [31:0] ls_addr_i;
    logic [31:0] ls_wdata_i;
    logic        ls_gnt_o;
    logic        ls_rvalid_o;
    logic [31:0] ls_rdata_o;
    logic        mem_en_o;
    logic        mem_wen_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_din_o;
    logic [31:0] mem_dout_i;

    modport slave (
        input  if_req_i, if_addr_i, if_kill_i,
        input  ls_req_i, ls_wen_i, ls_addr_i, ls_wdata_i,
        input  mem_dout_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
        output mem_en_o, mem_wen_o, mem_addr_o, mem_din_o
    );

    modport master (
        output if_req_i, if_addr_i, if_kill_i,
        output ls_req_i, ls_wen_i, ls_addr_i, ls_wdata_i,
        output mem_dout_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
        input  mem_en_o, mem_wen_o, mem_addr_o, mem_din_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch vs load/store arbiter for one pipelined single-port memory
module mem_arbiter #(
    parameter int MEM_LATENCY = 1,
    parameter int STARVE_MAX  = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    mem_arbiter_if.slave bus
);

    logic [3:0] starve_cnt;
    logic       starve_hit;
    logic       if_gnt;
    logic       ls_gnt;
    logic       push_vld;

    // One entry per memory access in flight: valid read, and whether load/store owns it.
    logic       tag_vld [MEM_LATENCY];
    logic       tag_ls  [MEM_LATENCY];

    always_comb begin
        starve_hit = (starve_cnt == 4'(STARVE_MAX));
        if_gnt     = 1'b0;
        ls_gnt     = 1'b0;
        if (!rst_i) begin
            if (bus.if_req_i && !bus.if_kill_i && (starve_hit || !bus.ls_req_i)) begin
                if_gnt = 1'b1;
            end else if (bus.ls_req_i) begin
                ls_gnt = 1'b1;
            end
        end
        push_vld = if_gnt || (ls_gnt && !bus.ls_wen_i);
    end

    assign bus.if_gnt_o   = if_gnt;
    assign bus.ls_gnt_o   = ls_gnt;
    assign bus.if_rdata_o = bus.mem_dout_i;
    assign bus.ls_rdata_o = bus.mem_dout_i;

    // A killed cycle neither counts as starvation nor forgives it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_cnt <= 4'd0;
        end else if (if_gnt || !bus.if_req_i) begin
            starve_cnt <= 4'd0;
        end else if (!bus.if_kill_i && starve_cnt != 4'hF) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus.mem_en_o   <= 1'b0;
            bus.mem_wen_o  <= 1'b0;
            bus.mem_addr_o <= 32'd0;
            bus.mem_din_o  <= 32'd0;
        end else begin
            bus.mem_en_o  <= if_gnt || ls_gnt;
            bus.mem_wen_o <= ls_gnt && bus.ls_wen_i;
            if (ls_gnt) begin
                bus.mem_addr_o <= bus.ls_addr_i;
                bus.mem_din_o  <= bus.ls_wdata_i;
            end else if (if_gnt) begin
                bus.mem_addr_o <= bus.if_addr_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                tag_vld[i] <= 1'b0;
                tag_ls[i]  <= 1'b0;
            end
            bus.if_rvalid_o <= 1'b0;
            bus.ls_rvalid_o <= 1'b0;
        end else begin
            tag_vld[0] <= push_vld;
            tag_ls[0]  <= ls_gnt;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                tag_vld[i] <= tag_vld[i-1] && !(bus.if_kill_i && !tag_ls[i-1]);
                tag_ls[i]  <= tag_ls[i-1];
            end
            bus.if_rvalid_o <= tag_vld[MEM_LATENCY-1] && !tag_ls[MEM_LATENCY-1] && !bus.if_kill_i;
            bus.ls_rvalid_o <= tag_vld[MEM_LATENCY-1] && tag_ls[MEM_LATENCY-1];
        end
    end

endmodule
